// File: rtl/somador_bcd_serial.sv
// Digit-serial BCD adder/subtractor, one digit per clock from the LSD.
// Ports: clk, reset (sync, high), inicio, modo, a, b, carry_in -> resultado, carry_out, erro, ocupado, pronto.
module somador_bcd_serial #(
    parameter int NUM_DIGITOS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inicio,
    input  logic                     modo,
    input  logic [4*NUM_DIGITOS-1:0] a,
    input  logic [4*NUM_DIGITOS-1:0] b,
    input  logic                     carry_in,
    output logic [4*NUM_DIGITOS-1:0] resultado,
    output logic                     carry_out,
    output logic                     erro,
    output logic                     ocupado,
    output logic                     pronto
);

    localparam int W  = 4 * NUM_DIGITOS;
    localparam int IW = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
    localparam logic [IW-1:0] ULTIMO = IW'(NUM_DIGITOS - 1);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        FIM    = 2'd2
    } estado_t;

    estado_t       estado, estado_n;
    logic [W-1:0]  a_sh, a_sh_n;
    logic [W-1:0]  b_sh, b_sh_n;
    logic [W-1:0]  acc, acc_n;
    logic [W-1:0]  resultado_n;
    logic [IW-1:0] idx, idx_n;
    logic          modo_r, modo_r_n;
    logic          c_r, c_r_n;
    logic          carry_out_n, erro_n, ocupado_n, pronto_n;

    logic [3:0]    b_ef;
    logic [4:0]    soma;
    logic          c_dig;
    logic [3:0]    digito;
    logic [W-1:0]  acc_dig;

    function automatic logic nibbles_ok(input logic [W-1:0] x);
        nibbles_ok = 1'b1;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (x[4*i +: 4] > 4'd9) begin
                nibbles_ok = 1'b0;
            end
        end
    endfunction

    // Subtraction is a + (9's complement of b) + c with c0 = ~borrow_in,
    // so the same decimal-correcting adder serves both modes.
    always_comb begin
        b_ef    = modo_r ? (4'd9 - b_sh[3:0]) : b_sh[3:0];
        soma    = {1'b0, a_sh[3:0]} + {1'b0, b_ef} + {4'd0, c_r};
        c_dig   = (soma > 5'd9);
        digito  = c_dig ? (soma[3:0] + 4'd6) : soma[3:0];
        // New digit enters at the top; after the last step digit 0 sits at [3:0].
        acc_dig = (acc >> 4) | (W'(digito) << (W - 4));
    end

    always_comb begin
        estado_n    = estado;
        a_sh_n      = a_sh;
        b_sh_n      = b_sh;
        acc_n       = acc;
        idx_n       = idx;
        modo_r_n    = modo_r;
        c_r_n       = c_r;
        resultado_n = resultado;
        carry_out_n = carry_out;
        erro_n      = erro;
        ocupado_n   = ocupado;
        pronto_n    = 1'b0;

        unique case (estado)
            OCIOSO: begin
                if (inicio) begin
                    a_sh_n   = a;
                    b_sh_n   = b;
                    modo_r_n = modo;
                    acc_n    = '0;
                    idx_n    = '0;
                    if (!(nibbles_ok(a) && nibbles_ok(b))) begin
                        estado_n    = FIM;
                        erro_n      = 1'b1;
                        resultado_n = '0;
                        carry_out_n = 1'b0;
                        pronto_n    = 1'b1;
                    end else begin
                        estado_n  = CALC;
                        ocupado_n = 1'b1;
                        c_r_n     = modo ? ~carry_in : carry_in;
                    end
                end
            end
            CALC: begin
                a_sh_n = a_sh >> 4;
                b_sh_n = b_sh >> 4;
                acc_n  = acc_dig;
                c_r_n  = c_dig;
                idx_n  = idx + 1'b1;
                if (idx == ULTIMO) begin
                    estado_n    = FIM;
                    resultado_n = acc_dig;
                    carry_out_n = modo_r ? ~c_dig : c_dig;
                    erro_n      = 1'b0;
                    ocupado_n   = 1'b0;
                    pronto_n    = 1'b1;
                end
            end
            FIM: begin
                estado_n = OCIOSO;
            end
            default: begin
                estado_n = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= OCIOSO;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            idx       <= '0;
            modo_r    <= 1'b0;
            c_r       <= 1'b0;
            resultado <= '0;
            carry_out <= 1'b0;
            erro      <= 1'b0;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
        end else begin
            estado    <= estado_n;
            a_sh      <= a_sh_n;
            b_sh      <= b_sh_n;
            acc       <= acc_n;
            idx       <= idx_n;
            modo_r    <= modo_r_n;
            c_r       <= c_r_n;
            resultado <= resultado_n;
            carry_out <= carry_out_n;
            erro      <= erro_n;
            ocupado   <= ocupado_n;
            pronto    <= pronto_n;
        end
    end

endmodule

// File: tb/tb_somador_bcd_serial.sv
// Self-checking bench for somador_bcd_serial at 1, 4 and 6 digits.
// Reference model works on plain integers converted from/to BCD.
module tb_somador_bcd_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, modo, carry_in;
    logic [2:0]  ini, co, er, oc, pr;
    logic [3:0]  a1, b1, r1;
    logic [15:0] a4, b4, r4;
    logic [23:0] a6, b6, r6;

    int n_cmp = 0;
    int n_err = 0;

    somador_bcd_serial #(.NUM_DIGITOS(1)) u1 (
        .clk(clk), .reset(reset), .inicio(ini[0]), .modo(modo),
        .a(a1), .b(b1), .carry_in(carry_in), .resultado(r1),
        .carry_out(co[0]), .erro(er[0]), .ocupado(oc[0]), .pronto(pr[0])
    );
    somador_bcd_serial #(.NUM_DIGITOS(4)) u4 (
        .clk(clk), .reset(reset), .inicio(ini[1]), .modo(modo),
        .a(a4), .b(b4), .carry_in(carry_in), .resultado(r4),
        .carry_out(co[1]), .erro(er[1]), .ocupado(oc[1]), .pronto(pr[1])
    );
    somador_bcd_serial #(.NUM_DIGITOS(6)) u6 (
        .clk(clk), .reset(reset), .inicio(ini[2]), .modo(modo),
        .a(a6), .b(b6), .carry_in(carry_in), .resultado(r6),
        .carry_out(co[2]), .erro(er[2]), .ocupado(oc[2]), .pronto(pr[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nd(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 4 : 6);
    endfunction

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic longint bcd2int(input logic [23:0] x, input int n);
        longint v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [23:0] int2bcd(input longint v, input int n);
        logic [23:0] r = '0;
        longint t = v;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic void model(input int n, input logic md, input logic cin,
                                  input logic [23:0] av, input logic [23:0] bv,
                                  output logic [23:0] r, output logic c, output logic e);
        longint m, x, y, s;
        e = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) e = 1'b1;
        end
        r = '0;
        c = 1'b0;
        if (!e) begin
            m = pow10(n);
            x = bcd2int(av, n);
            y = bcd2int(bv, n);
            if (!md) begin
                s = x + y + longint'(cin);
                c = (s >= m);
                s = s % m;
            end else begin
                s = x - y - longint'(cin);
                c = (s < 0);
                if (s < 0) s = s + m;
            end
            r = int2bcd(s, n);
        end
    endfunction

    task automatic set_in(input int sel, input logic [23:0] av, input logic [23:0] bv);
        case (sel)
            0: begin a1 = av[3:0];  b1 = bv[3:0];  end
            1: begin a4 = av[15:0]; b4 = bv[15:0]; end
            default: begin a6 = av; b6 = bv; end
        endcase
    endtask

    task automatic get_out(input int sel, output logic [23:0] r, output logic c, output logic e);
        case (sel)
            0: r = {20'd0, r1};
            1: r = {8'd0, r4};
            default: r = r6;
        endcase
        c = co[sel];
        e = er[sel];
    endtask

    task automatic run_op(input int sel, input logic md, input logic cin,
                          input logic [23:0] av, input logic [23:0] bv, input string tag);
        logic [23:0] xr, r;
        logic xc, xe, c, e;
        int k, cnt;
        model(nd(sel), md, cin, av, bv, xr, xc, xe);
        @(posedge clk); #1;
        modo = md; carry_in = cin; set_in(sel, av, bv); ini[sel] = 1'b1;
        @(posedge clk); #1;
        ini[sel] = 1'b0; modo = ~md; carry_in = ~cin;
        set_in(sel, 24'($urandom()), 24'($urandom()));
        k = 0;
        cnt = 0;
        while (!pr[sel] && k <= 20) begin
            if (oc[sel]) cnt++;
            @(posedge clk); #1;
            k++;
        end
        get_out(sel, r, c, e);
        check({tag, ".lat"}, k, xe ? 0 : nd(sel));
        check({tag, ".res"}, r, xr);
        check({tag, ".cout"}, c, xc);
        check({tag, ".erro"}, e, xe);
        check({tag, ".ocup"}, cnt, xe ? 0 : nd(sel));
        @(posedge clk); #1;
        check({tag, ".pulse"}, pr[sel], 0);
    endtask

    initial begin
        int pulses [$];
        int np;
        logic [23:0] ra, rb;
        int sel;

        reset = 1'b1; ini = '0; modo = 1'b0; carry_in = 1'b0;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0; a6 = '0; b6 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.res", r4, 0);
        check("rst.flags", {co[1], er[1], oc[1], pr[1]}, 0);
        check("rst.n1n6", {r1, r6, co[0], co[2], er[0], er[2], pr[0], pr[2]}, 0);
        reset = 1'b0;

        run_op(1, 0, 0, 24'h0999, 24'h0001, "add0999");
        run_op(1, 0, 0, 24'h9999, 24'h0001, "ovf9999");
        run_op(1, 0, 1, 24'h4567, 24'h5432, "ovfcin");
        run_op(1, 1, 0, 24'h0050, 24'h0025, "sub50");
        run_op(1, 1, 0, 24'h0003, 24'h0005, "subneg");
        run_op(1, 1, 1, 24'h1000, 24'h0000, "subbin");
        run_op(1, 0, 0, 24'h00A0, 24'h0001, "invalid");
        run_op(1, 0, 0, 24'h0012, 24'h0034, "clrerro");

        // inicio pulsed during CALC must be dropped
        @(posedge clk); #1;
        modo = 0; carry_in = 0; a4 = 16'h1234; b4 = 16'h1111; ini[1] = 1'b1;
        @(posedge clk); #1; ini[1] = 1'b0;
        @(posedge clk); #1; ini[1] = 1'b1; a4 = 16'h9999; b4 = 16'h9999; modo = 1;
        @(posedge clk); #1; ini[1] = 1'b0;
        np = 0;
        while (!pr[1] && np < 20) begin
            @(posedge clk); #1;
            np++;
        end
        check("ign.res", r4, 16'h2345);
        check("ign.cout", co[1], 0);
        np = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (pr[1] || oc[1]) np++;
        end
        check("ign.noqueue", np, 0);

        // inicio held high: one result every 6 cycles
        modo = 0; carry_in = 0; a4 = 16'h0100; b4 = 16'h0200; ini[1] = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            if (pr[1]) pulses.push_back(cyc);
        end
        ini[1] = 1'b0;
        check("held.count", pulses.size() >= 3, 1);
        if (pulses.size() >= 3) begin
            check("held.gap1", pulses[1] - pulses[0], 6);
            check("held.gap2", pulses[2] - pulses[1], 6);
        end
        check("held.res", r4, 16'h0300);
        repeat (10) @(posedge clk);

        // reset after two digits aborts silently
        #1;
        modo = 0; carry_in = 0; a4 = 16'h1234; b4 = 16'h0001; ini[1] = 1'b1;
        @(posedge clk); #1; ini[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst.res", r4, 0);
        check("mrst.flags", {co[1], er[1], oc[1], pr[1]}, 0);
        np = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (pr[1]) np++;
        end
        check("mrst.nopronto", np, 0);
        run_op(1, 0, 0, 24'h1234, 24'h4321, "postrst");

        run_op(0, 0, 0, 24'h9, 24'h1, "n1ovf");
        run_op(0, 0, 1, 24'h4, 24'h3, "n1add");
        run_op(0, 1, 0, 24'h3, 24'h5, "n1sub");
        run_op(2, 0, 0, 24'h099999, 24'h000001, "n6add");
        run_op(2, 0, 1, 24'h999999, 24'h000000, "n6ovf");
        run_op(2, 0, 0, 24'h123456, 24'h654321, "n6mix");

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 2);
            ra = '0;
            rb = '0;
            for (int d = 0; d < nd(sel); d++) begin
                ra[4*d +: 4] = 4'($urandom_range(0, 9));
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) begin
                int p;
                p = $urandom_range(0, nd(sel) - 1);
                rb[4*p +: 4] = 4'($urandom_range(10, 15));
            end
            run_op(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/somador_bcd_serial.md
# somador_bcd_serial

Parametrised, digit-serial BCD adder/subtractor for the alarm's time-arithmetic path. It handles alarm offsets, snooze increments and minute/hour differences. It accepts two packed `NUM_DIGITOS`-digit BCD operands on a start pulse, processes one digit per clock from the least-significant digit, and returns a decimal-corrected result with carry/borrow and an invalid-digit flag. It replaces single-digit combinational BCD addition wherever multi-digit or subtract operation is required.

## Interface
- `NUM_DIGITOS`, default 4: number of BCD digits per operand (≥1).
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `inicio` input 1: start request; sampled only in OCIOSO.
- `modo` input 1: 0 = add (a+b+carry_in), 1 = subtract (a−b−carry_in, carry_in acts as borrow-in).
- `a` input 4·NUM_DIGITOS: operand A, packed BCD, digit 0 in bits [3:0].
- `b` input 4·NUM_DIGITOS: operand B, same packing.
- `carry_in` input 1: carry-in (add) / borrow-in (subtract).
- `resultado` output 4·NUM_DIGITOS: packed BCD result.
- `carry_out` output 1: decimal carry-out (add) / borrow-out (subtract).
- `erro` output 1: an operand nibble exceeded 9.
- `ocupado` output 1: operation in progress.
- `pronto` output 1: one-cycle pulse, results valid.

## Operation
- FSM states: OCIOSO, CALC, FIM.
- Reset (any state, mid-operation included): state OCIOSO; `resultado`=0, `carry_out`=0, `erro`=0, `ocupado`=0, `pronto`=0; internal registers cleared; an aborted operation never produces `pronto`.
- OCIOSO, `inicio`=1 at edge E0: latch `a`, `b`, `modo`, `carry_in`; check every nibble of `a` and `b`.
  - Any nibble >9: go to FIM with `erro`=1, `resultado`=0, `carry_out`=0.
  - All nibbles valid: go to CALC with digit index 0, `ocupado`=1, and internal carry c0 = `carry_in` (add) or ~`carry_in` (subtract).
- CALC, digit i per edge:
  - b'_i = b_i (add) or 9−b_i (subtract).
  - s = a_i + b'_i + c, 5-bit, range 0..19.
  - If s>9: digit = (s+6)[3:0], c=1. Otherwise: digit = s[3:0], c=0.
  - The digit is stored in an internal result register. `resultado` does not change during CALC.
- After digit NUM_DIGITOS−1: go to FIM.
  - `resultado` = internal register.
  - `carry_out` = c (add) or ~c (subtract).
  - `erro`=0, `ocupado`=0.
- FIM: `pronto`=1 for exactly one cycle, then OCIOSO.
- Subtract with borrow-out=1 yields the ten's complement, e.g. 0003−0005 = 9998.
- Add overflow wraps modulo 10^NUM_DIGITOS with `carry_out`=1.
- `inicio` in CALC or FIM: ignored, never queued. Operand/mode changes after E0: no effect.
- `resultado`, `carry_out`, `erro` hold their values until the next accepted `inicio` completes or reset.

## Timing
- Registered outputs only; no combinational input-to-output path.
- Valid operation: `inicio` sampled at E0 → `ocupado` high from E0 to E(NUM_DIGITOS) → `pronto` high during the cycle following E(NUM_DIGITOS). Latency NUM_DIGITOS+1 edges to `pronto`, NUM_DIGITOS+2 cycles to ready for a new start.
- Invalid operands: `pronto` and `erro` high in the cycle following E0. `ocupado` stays 0.
- Back-to-back: `inicio` held high is accepted again at the edge leaving FIM. Throughput is one operation per NUM_DIGITOS+2 cycles.
- `pronto` is asserted only together with the final result values; outputs are never partially updated.

## Test plan
- NUM_DIGITOS=4, add: a=0999, b=0001, carry_in=0 → `resultado`=1000, `carry_out`=0; `pronto` one cycle, 5 edges after `inicio`; `ocupado` high exactly 4 cycles.
- Add overflow: a=9999, b=0001, carry_in=0 → `resultado`=0000, `carry_out`=1. Also a=4567, b=5432, carry_in=1 → 0000, `carry_out`=1.
- Subtract, modo=1: a=0050, b=0025, carry_in=0 → 0025, `carry_out`=0. Also a=0003, b=0005 → 9998, `carry_out`=1. Also a=1000, b=0000, carry_in=1 → 0999, `carry_out`=0.
- Invalid digit: a=0x00A0, b=0001 → `erro`=1, `resultado`=0000, `carry_out`=0, `pronto` in the cycle after `inicio`, `ocupado` never high. The next valid operation clears `erro`.
- Handshake: pulse `inicio` again during CALC with different operands → ignored, first result unaffected. Hold `inicio` high continuously → consecutive `pronto` pulses spaced 6 cycles apart.
- Reset mid-CALC, after 2 digits: all outputs 0 next cycle, no `pronto`. A new operation afterwards completes correctly. Repeat the add cases with NUM_DIGITOS=1 and 6.
